// File: rtl/e203_exu_longp_retire_sched.sv
// In-order retire scheduler for long-pipe completions tracked by the OITF.
// Optional FP regfile tagging of write-backs: define E203_LONGP_RETIRE_FPU_EN.
module e203_exu_longp_retire_sched #(
    parameter int unsigned REQ_NUM = 3,
    parameter int unsigned ITAG_W  = 1,
    parameter int unsigned RFIDX_W = 5,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [REQ_NUM-1:0]        req_valid,
    output logic [REQ_NUM-1:0]        req_ready,
    input  logic [REQ_NUM*ITAG_W-1:0] req_itag,
    input  logic [REQ_NUM*XLEN-1:0]   req_wdat,
    input  logic [REQ_NUM-1:0]        req_err,

    input  logic                      oitf_empty,
    input  logic [ITAG_W-1:0]         oitf_ret_ptr,
    input  logic [RFIDX_W-1:0]        oitf_ret_rdidx,
    input  logic                      oitf_ret_rdwen,
    input  logic                      oitf_ret_rdfpu,
    input  logic [PC_W-1:0]           oitf_ret_pc,
    output logic                      oitf_ret_ena,

    output logic                      wbck_o_valid,
    input  logic                      wbck_o_ready,
    output logic [XLEN-1:0]           wbck_o_wdat,
    output logic [RFIDX_W-1:0]        wbck_o_rdidx,
    output logic                      wbck_o_rdfpu,

    output logic                      excp_o_valid,
    input  logic                      excp_o_ready,
    output logic [PC_W-1:0]           excp_o_pc
);

    localparam int unsigned SEL_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WBCK,
        EXCP,
        RET
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [REQ_NUM-1:0] buf_vld;
    logic [ITAG_W-1:0]  buf_itag [REQ_NUM];
    logic [XLEN-1:0]    buf_wdat [REQ_NUM];
    logic [REQ_NUM-1:0] buf_err;

    logic [REQ_NUM-1:0] match;
    logic               any_match;
    logic [SEL_W-1:0]   sel;
    logic               load;
    logic               sel_err;
    logic [XLEN-1:0]    sel_wdat;

    logic               wbck_vld_r;
    logic               excp_vld_r;
    logic [XLEN-1:0]    wdat_r;
    logic [RFIDX_W-1:0] rdidx_r;
    logic [PC_W-1:0]    pc_r;

    assign req_ready = ~buf_vld;

    // Only the entry whose itag equals the retire pointer may leave; lowest index wins a tie.
    always_comb begin
        match = '0;
        for (int unsigned k = 0; k < REQ_NUM; k++) begin
            match[k] = buf_vld[k] & ~oitf_empty & (buf_itag[k] == oitf_ret_ptr);
        end
    end

    always_comb begin
        sel       = '0;
        any_match = 1'b0;
        for (int unsigned k = 0; k < REQ_NUM; k++) begin
            if (match[k] && !any_match) begin
                sel       = SEL_W'(k);
                any_match = 1'b1;
            end
        end
    end

    assign load     = (state == IDLE) & any_match;
    assign sel_err  = buf_err[sel];
    assign sel_wdat = buf_wdat[sel];

    // A buffer being released is full, so it cannot also accept in that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_vld <= '0;
            buf_err <= '0;
            for (int unsigned k = 0; k < REQ_NUM; k++) begin
                buf_itag[k] <= '0;
                buf_wdat[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < REQ_NUM; k++) begin
                if (load && (sel == SEL_W'(k))) begin
                    buf_vld[k] <= 1'b0;
                end else if (req_valid[k] && !buf_vld[k]) begin
                    buf_vld[k]  <= 1'b1;
                    buf_itag[k] <= req_itag[k*ITAG_W +: ITAG_W];
                    buf_wdat[k] <= req_wdat[k*XLEN +: XLEN];
                    buf_err[k]  <= req_err[k];
                end
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        oitf_ret_ena = 1'b0;
        case (state)
            IDLE: begin
                if (any_match) begin
                    if (sel_err) begin
                        state_nxt = EXCP;
                    end else if (oitf_ret_rdwen) begin
                        state_nxt = WBCK;
                    end else begin
                        state_nxt = RET;
                    end
                end
            end
            WBCK: begin
                if (wbck_o_ready) begin
                    oitf_ret_ena = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            EXCP: begin
                if (excp_o_ready) begin
                    oitf_ret_ena = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            RET: begin
                oitf_ret_ena = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Valids are flops fed from the next state so they are glitch-free and hold until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wbck_vld_r <= 1'b0;
            excp_vld_r <= 1'b0;
        end else begin
            state      <= state_nxt;
            wbck_vld_r <= (state_nxt == WBCK);
            excp_vld_r <= (state_nxt == EXCP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdat_r  <= '0;
            rdidx_r <= '0;
            pc_r    <= '0;
        end else if (load) begin
            wdat_r  <= sel_wdat;
            rdidx_r <= oitf_ret_rdidx;
            pc_r    <= oitf_ret_pc;
        end
    end

`ifdef E203_LONGP_RETIRE_FPU_EN
    logic rdfpu_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdfpu_r <= 1'b0;
        end else if (load) begin
            rdfpu_r <= oitf_ret_rdfpu;
        end
    end

    assign wbck_o_rdfpu = rdfpu_r;
`else
    logic unused_rdfpu;

    assign unused_rdfpu = oitf_ret_rdfpu;
    assign wbck_o_rdfpu = 1'b0;
`endif

    assign wbck_o_valid = wbck_vld_r;
    assign excp_o_valid = excp_vld_r;
    assign wbck_o_wdat  = wdat_r;
    assign wbck_o_rdidx = rdidx_r;
    assign excp_o_pc    = pc_r;

endmodule

// File: tb/tb_e203_exu_longp_retire_sched.sv
// Bench for e203_exu_longp_retire_sched: table vectors, directed corner sequences, random OITF scoreboard.
module tb_e203_exu_longp_retire_sched;

    localparam int unsigned REQ_NUM = 3;
    localparam int unsigned ITAG_W  = 1;
    localparam int unsigned RFIDX_W = 5;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_W    = 32;

    logic                      clk;
    logic                      rst;
    logic [REQ_NUM-1:0]        req_valid;
    logic [REQ_NUM-1:0]        req_ready;
    logic [REQ_NUM*ITAG_W-1:0] req_itag;
    logic [REQ_NUM*XLEN-1:0]   req_wdat;
    logic [REQ_NUM-1:0]        req_err;
    logic                      oitf_empty;
    logic [ITAG_W-1:0]         oitf_ret_ptr;
    logic [RFIDX_W-1:0]        oitf_ret_rdidx;
    logic                      oitf_ret_rdwen;
    logic                      oitf_ret_rdfpu;
    logic [PC_W-1:0]           oitf_ret_pc;
    logic                      oitf_ret_ena;
    logic                      wbck_o_valid;
    logic                      wbck_o_ready;
    logic [XLEN-1:0]           wbck_o_wdat;
    logic [RFIDX_W-1:0]        wbck_o_rdidx;
    logic                      wbck_o_rdfpu;
    logic                      excp_o_valid;
    logic                      excp_o_ready;
    logic [PC_W-1:0]           excp_o_pc;

    e203_exu_longp_retire_sched #(
        .REQ_NUM (REQ_NUM),
        .ITAG_W  (ITAG_W),
        .RFIDX_W (RFIDX_W),
        .XLEN    (XLEN),
        .PC_W    (PC_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_itag       (req_itag),
        .req_wdat       (req_wdat),
        .req_err        (req_err),
        .oitf_empty     (oitf_empty),
        .oitf_ret_ptr   (oitf_ret_ptr),
        .oitf_ret_rdidx (oitf_ret_rdidx),
        .oitf_ret_rdwen (oitf_ret_rdwen),
        .oitf_ret_rdfpu (oitf_ret_rdfpu),
        .oitf_ret_pc    (oitf_ret_pc),
        .oitf_ret_ena   (oitf_ret_ena),
        .wbck_o_valid   (wbck_o_valid),
        .wbck_o_ready   (wbck_o_ready),
        .wbck_o_wdat    (wbck_o_wdat),
        .wbck_o_rdidx   (wbck_o_rdidx),
        .wbck_o_rdfpu   (wbck_o_rdfpu),
        .excp_o_valid   (excp_o_valid),
        .excp_o_ready   (excp_o_ready),
        .excp_o_pc      (excp_o_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int unsigned        unit;
        logic [ITAG_W-1:0]  itag;
        logic [XLEN-1:0]    wdat;
        logic               err;
        logic               rdwen;
        logic               rdfpu;
        logic [RFIDX_W-1:0] rdidx;
        logic [PC_W-1:0]    pc;
        logic               exp_wv;
        logic               exp_ev;
    } vec_t;

    typedef struct {
        logic [ITAG_W-1:0]  itag;
        int unsigned        unit;
        logic               err;
        logic               rdwen;
        logic               rdfpu;
        logic [RFIDX_W-1:0] rdidx;
        logic [PC_W-1:0]    pc;
        logic [XLEN-1:0]    wdat;
        logic               sent;
    } ent_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic exp_rdfpu(input logic v);
`ifdef E203_LONGP_RETIRE_FPU_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    task automatic idle_inputs();
        req_valid      = '0;
        req_itag       = '0;
        req_wdat       = '0;
        req_err        = '0;
        oitf_empty     = 1'b1;
        oitf_ret_ptr   = '0;
        oitf_ret_rdidx = '0;
        oitf_ret_rdwen = 1'b0;
        oitf_ret_rdfpu = 1'b0;
        oitf_ret_pc    = '0;
        wbck_o_ready   = 1'b0;
        excp_o_ready   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_req(input int unsigned k, input logic [ITAG_W-1:0] itag,
                           input logic [XLEN-1:0] wdat, input logic err);
        req_valid[k]                 = 1'b1;
        req_itag[k*ITAG_W +: ITAG_W] = itag;
        req_wdat[k*XLEN +: XLEN]     = wdat;
        req_err[k]                   = err;
    endtask

    task automatic set_head(input logic [ITAG_W-1:0] ptr, input logic rdwen,
                            input logic [RFIDX_W-1:0] rdidx, input logic rdfpu,
                            input logic [PC_W-1:0] pc);
        oitf_empty     = 1'b0;
        oitf_ret_ptr   = ptr;
        oitf_ret_rdwen = rdwen;
        oitf_ret_rdidx = rdidx;
        oitf_ret_rdfpu = rdfpu;
        oitf_ret_pc    = pc;
    endtask

    task automatic run_vec(input vec_t v);
        do_reset();
        @(negedge clk);
        set_head(v.itag, v.rdwen, v.rdidx, v.rdfpu, v.pc);
        set_req(v.unit, v.itag, v.wdat, v.err);
        wbck_o_ready = 1'b1;
        excp_o_ready = 1'b1;
        #4;
        chk("vec_rdy_accept", 64'(req_ready[v.unit]), 64'd1);
        chk("vec_ena_n0", 64'(oitf_ret_ena), 64'd0);
        @(negedge clk);
        req_valid = '0;
        #4;
        chk("vec_rdy_full", 64'(req_ready[v.unit]), 64'd0);
        chk("vec_vld_n1", 64'({wbck_o_valid, excp_o_valid}), 64'd0);
        chk("vec_ena_n1", 64'(oitf_ret_ena), 64'd0);
        @(negedge clk);
        #4;
        chk("vec_wvld", 64'(wbck_o_valid), 64'(v.exp_wv));
        chk("vec_evld", 64'(excp_o_valid), 64'(v.exp_ev));
        chk("vec_ena_n2", 64'(oitf_ret_ena), 64'd1);
        chk("vec_rdy_rel", 64'(req_ready[v.unit]), 64'd1);
        if (v.exp_wv) begin
            chk("vec_wdat", 64'(wbck_o_wdat), 64'(v.wdat));
            chk("vec_rdidx", 64'(wbck_o_rdidx), 64'(v.rdidx));
            chk("vec_rdfpu", 64'(wbck_o_rdfpu), 64'(exp_rdfpu(v.rdfpu)));
        end
        if (v.exp_ev) begin
            chk("vec_pc", 64'(excp_o_pc), 64'(v.pc));
        end
        @(negedge clk);
        oitf_empty = 1'b1;
        #4;
        chk("vec_vld_n3", 64'({wbck_o_valid, excp_o_valid}), 64'd0);
        chk("vec_ena_n3", 64'(oitf_ret_ena), 64'd0);
        chk("vec_rdy_n3", 64'(req_ready), 64'h7);
    endtask

    vec_t vt[6];
    ent_t oq[$];
    ent_t e;
    ent_t h;
    int   sel[REQ_NUM];
    logic [ITAG_W-1:0] alloc_itag;
    int   idle_cnt;
    int   n_ret;

    initial begin
        rst = 1'b1;
        idle_inputs();

        vt[0] = '{0, 1'b0, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 5'd5,  32'h8000_0000, 1'b1, 1'b0};
        vt[1] = '{1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 5'd31, 32'h8000_0010, 1'b1, 1'b0};
        vt[2] = '{2, 1'b0, 32'h0000_5555, 1'b1, 1'b1, 1'b0, 5'd9,  32'h8000_0040, 1'b0, 1'b1};
        vt[3] = '{0, 1'b1, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 5'd12, 32'h8000_0020, 1'b0, 1'b0};
        vt[4] = '{2, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 5'd0,  32'h8000_0024, 1'b1, 1'b0};
        vt[5] = '{1, 1'b0, 32'h0000_0abc, 1'b1, 1'b0, 1'b0, 5'd1,  32'h0000_1000, 1'b0, 1'b1};

        // Reset state.
        do_reset();
        @(negedge clk);
        #4;
        chk("rst_ready", 64'(req_ready), 64'h7);
        chk("rst_wvld", 64'(wbck_o_valid), 64'd0);
        chk("rst_evld", 64'(excp_o_valid), 64'd0);
        chk("rst_ena", 64'(oitf_ret_ena), 64'd0);
        chk("rst_wdat", 64'(wbck_o_wdat), 64'd0);
        chk("rst_rdidx", 64'(wbck_o_rdidx), 64'd0);
        chk("rst_pc", 64'(excp_o_pc), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vt[i]);
        end

        // Reset asserted while a write-back is pending and another buffer is full.
        do_reset();
        @(negedge clk);
        set_head(1'b0, 1'b1, 5'd6, 1'b0, 32'h100);
        set_req(0, 1'b0, 32'hCAFE, 1'b0);
        set_req(1, 1'b1, 32'hBEEF, 1'b0);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #4;
        chk("rstw_wvld_pre", 64'(wbck_o_valid), 64'd1);
        chk("rstw_rdy1_pre", 64'(req_ready[1]), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_wvld", 64'(wbck_o_valid), 64'd0);
        chk("rstw_ena", 64'(oitf_ret_ena), 64'd0);
        chk("rstw_ready", 64'(req_ready), 64'h7);
        chk("rstw_wdat", 64'(wbck_o_wdat), 64'd0);
        wbck_o_ready = 1'b1;
        #3;
        chk("rstw_ena_rdy", 64'(oitf_ret_ena), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Out-of-order completion: younger itag waits for the pointer.
        do_reset();
        @(negedge clk);
        set_head(1'b0, 1'b1, 5'd3, 1'b0, 32'h200);
        set_req(1, 1'b1, 32'hB1, 1'b0);
        wbck_o_ready = 1'b1;
        excp_o_ready = 1'b1;
        #4;
        chk("ooo_acc1", 64'(req_ready[1]), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = '0;
            #4;
            chk("ooo_wait_rdy1", 64'(req_ready[1]), 64'd0);
            chk("ooo_wait_wvld", 64'(wbck_o_valid), 64'd0);
            chk("ooo_wait_ena", 64'(oitf_ret_ena), 64'd0);
        end
        @(negedge clk);
        set_req(0, 1'b0, 32'hA0, 1'b0);
        #4;
        chk("ooo_acc0", 64'(req_ready[0]), 64'd1);
        @(negedge clk);
        req_valid = '0;
        #4;
        chk("ooo_load0_wvld", 64'(wbck_o_valid), 64'd0);
        @(negedge clk);
        #4;
        chk("ooo_first_wvld", 64'(wbck_o_valid), 64'd1);
        chk("ooo_first_wdat", 64'(wbck_o_wdat), 64'hA0);
        chk("ooo_first_rdidx", 64'(wbck_o_rdidx), 64'd3);
        chk("ooo_first_ena", 64'(oitf_ret_ena), 64'd1);
        chk("ooo_first_rdy1", 64'(req_ready[1]), 64'd0);
        @(negedge clk);
        set_head(1'b1, 1'b1, 5'd7, 1'b0, 32'h204);
        #4;
        chk("ooo_load1_wvld", 64'(wbck_o_valid), 64'd0);
        chk("ooo_load1_ena", 64'(oitf_ret_ena), 64'd0);
        chk("ooo_load1_rdy1", 64'(req_ready[1]), 64'd0);
        @(negedge clk);
        #4;
        chk("ooo_second_wvld", 64'(wbck_o_valid), 64'd1);
        chk("ooo_second_wdat", 64'(wbck_o_wdat), 64'hB1);
        chk("ooo_second_rdidx", 64'(wbck_o_rdidx), 64'd7);
        chk("ooo_second_ena", 64'(oitf_ret_ena), 64'd1);
        chk("ooo_second_rdy1", 64'(req_ready[1]), 64'd1);

        // Exception held by excp_o_ready low for three cycles.
        do_reset();
        @(negedge clk);
        set_head(1'b0, 1'b1, 5'd10, 1'b0, 32'h8000_0040);
        set_req(2, 1'b0, 32'h77, 1'b1);
        wbck_o_ready = 1'b1;
        excp_o_ready = 1'b0;
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #4;
            chk("exc_hold_evld", 64'(excp_o_valid), 64'd1);
            chk("exc_hold_pc", 64'(excp_o_pc), 64'h8000_0040);
            chk("exc_hold_wvld", 64'(wbck_o_valid), 64'd0);
            chk("exc_hold_ena", 64'(oitf_ret_ena), 64'd0);
        end
        @(negedge clk);
        excp_o_ready = 1'b1;
        #4;
        chk("exc_acc_evld", 64'(excp_o_valid), 64'd1);
        chk("exc_acc_pc", 64'(excp_o_pc), 64'h8000_0040);
        chk("exc_acc_wvld", 64'(wbck_o_valid), 64'd0);
        chk("exc_acc_ena", 64'(oitf_ret_ena), 64'd1);
        @(negedge clk);
        oitf_empty = 1'b1;
        #4;
        chk("exc_after_evld", 64'(excp_o_valid), 64'd0);
        chk("exc_after_ena", 64'(oitf_ret_ena), 64'd0);

        // Write-back stalled four cycles with a second completion buffered.
        do_reset();
        @(negedge clk);
        set_head(1'b0, 1'b1, 5'd4, 1'b0, 32'h300);
        set_req(0, 1'b0, 32'h111, 1'b0);
        set_req(1, 1'b1, 32'h222, 1'b0);
        wbck_o_ready = 1'b0;
        excp_o_ready = 1'b1;
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #4;
            chk("stl_hold_wvld", 64'(wbck_o_valid), 64'd1);
            chk("stl_hold_wdat", 64'(wbck_o_wdat), 64'h111);
            chk("stl_hold_rdidx", 64'(wbck_o_rdidx), 64'd4);
            chk("stl_hold_ena", 64'(oitf_ret_ena), 64'd0);
            chk("stl_hold_rdy1", 64'(req_ready[1]), 64'd0);
        end
        @(negedge clk);
        wbck_o_ready = 1'b1;
        #4;
        chk("stl_acc_wdat", 64'(wbck_o_wdat), 64'h111);
        chk("stl_acc_ena", 64'(oitf_ret_ena), 64'd1);
        @(negedge clk);
        set_head(1'b1, 1'b1, 5'd9, 1'b0, 32'h304);
        #4;
        chk("stl_gap_wvld", 64'(wbck_o_valid), 64'd0);
        chk("stl_gap_ena", 64'(oitf_ret_ena), 64'd0);
        @(negedge clk);
        #4;
        chk("stl_second_wvld", 64'(wbck_o_valid), 64'd1);
        chk("stl_second_wdat", 64'(wbck_o_wdat), 64'h222);
        chk("stl_second_rdidx", 64'(wbck_o_rdidx), 64'd9);
        chk("stl_second_ena", 64'(oitf_ret_ena), 64'd1);

        // oitf_empty blocks a matching itag.
        do_reset();
        @(negedge clk);
        set_req(0, 1'b0, 32'h99, 1'b0);
        wbck_o_ready = 1'b1;
        excp_o_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = '0;
            #4;
            chk("emp_wvld", 64'(wbck_o_valid), 64'd0);
            chk("emp_ena", 64'(oitf_ret_ena), 64'd0);
            chk("emp_rdy0", 64'(req_ready[0]), 64'd0);
        end
        @(negedge clk);
        set_head(1'b0, 1'b1, 5'd2, 1'b0, 32'h0);
        #4;
        chk("emp_load_wvld", 64'(wbck_o_valid), 64'd0);
        @(negedge clk);
        #4;
        chk("emp_rel_wvld", 64'(wbck_o_valid), 64'd1);
        chk("emp_rel_wdat", 64'(wbck_o_wdat), 64'h99);
        chk("emp_rel_ena", 64'(oitf_ret_ena), 64'd1);

        // Random traffic against an in-order OITF scoreboard.
        do_reset();
        alloc_itag = '0;
        idle_cnt   = 0;
        n_ret      = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (oq.size() < 2 && $urandom_range(0, 2) != 0) begin
                e.itag     = alloc_itag;
                alloc_itag = alloc_itag + 1'b1;
                e.unit     = $urandom_range(0, REQ_NUM - 1);
                e.err      = ($urandom_range(0, 7) == 0);
                e.rdwen    = ($urandom_range(0, 3) != 0);
                e.rdfpu    = 1'($urandom_range(0, 1));
                e.rdidx    = RFIDX_W'($urandom_range(0, 31));
                e.pc       = $urandom;
                e.wdat     = $urandom;
                e.sent     = 1'b0;
                oq.push_back(e);
            end
            if (oq.size() == 0) begin
                oitf_empty     = 1'b1;
                oitf_ret_ptr   = ITAG_W'($urandom);
                oitf_ret_rdwen = 1'($urandom_range(0, 1));
                oitf_ret_rdidx = RFIDX_W'($urandom);
                oitf_ret_pc    = $urandom;
            end else begin
                set_head(oq[0].itag, oq[0].rdwen, oq[0].rdidx, oq[0].rdfpu, oq[0].pc);
            end
            for (int k = 0; k < REQ_NUM; k++) begin
                sel[k] = -1;
                for (int j = 0; j < oq.size(); j++) begin
                    if (sel[k] < 0 && oq[j].unit == k && !oq[j].sent) begin
                        sel[k] = j;
                    end
                end
                if (sel[k] >= 0 && $urandom_range(0, 3) != 0) begin
                    set_req(k, oq[sel[k]].itag, oq[sel[k]].wdat, oq[sel[k]].err);
                end else begin
                    req_valid[k]                 = 1'b0;
                    req_itag[k*ITAG_W +: ITAG_W] = ITAG_W'($urandom);
                    req_err[k]                   = 1'($urandom_range(0, 1));
                end
            end
            wbck_o_ready = ($urandom_range(0, 3) != 0);
            excp_o_ready = ($urandom_range(0, 3) != 0);
            #4;
            chk("rnd_excl", 64'(wbck_o_valid & excp_o_valid), 64'd0);
            for (int k = 0; k < REQ_NUM; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    e = oq[sel[k]];
                    e.sent = 1'b1;
                    oq[sel[k]] = e;
                end
            end
            if (oitf_ret_ena) begin
                idle_cnt = 0;
                if (oq.size() == 0) begin
                    chk("rnd_ret_empty", 64'(oitf_ret_ena), 64'd0);
                end else begin
                    h = oq.pop_front();
                    n_ret++;
                    chk("rnd_sent", 64'(h.sent), 64'd1);
                    chk("rnd_kind", 64'({wbck_o_valid, excp_o_valid}), 64'({!h.err && h.rdwen, h.err}));
                    if (!h.err && h.rdwen) begin
                        chk("rnd_wdat", 64'(wbck_o_wdat), 64'(h.wdat));
                        chk("rnd_rdidx", 64'(wbck_o_rdidx), 64'(h.rdidx));
                        chk("rnd_rdfpu", 64'(wbck_o_rdfpu), 64'(exp_rdfpu(h.rdfpu)));
                    end
                    if (h.err) begin
                        chk("rnd_pc", 64'(excp_o_pc), 64'(h.pc));
                    end
                end
            end else if (oq.size() > 0) begin
                idle_cnt++;
                if (idle_cnt > 200) begin
                    chk("rnd_timeout", 64'(idle_cnt), 64'd0);
                    break;
                end
            end
        end
        chk("rnd_progress", 64'(n_ret > 200), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
